// File: rtl/ikaopm_pkg.sv
// ikaopm_pkg
//   Shared definitions for the accumulator scheduling slice:
//   - lock_state_t : frame-lock FSM states
//   - CYC_*        : master-cycle numbers decoded into accumulator strobes
//   - sample_t     : signed 16-bit accumulator sample
package ikaopm_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_ACQUIRE,
    ST_LOCKED
  } lock_state_t;

  typedef logic [4:0] cyc_t;

  localparam cyc_t CYC_00 = 5'd0;
  localparam cyc_t CYC_01 = 5'd1;
  localparam cyc_t CYC_06 = 5'd6;
  localparam cyc_t CYC_12 = 5'd12;
  localparam cyc_t CYC_16 = 5'd16;
  localparam cyc_t CYC_22 = 5'd22;
  localparam cyc_t CYC_29 = 5'd29;
  localparam cyc_t CYC_31 = 5'd31;

  typedef logic signed [15:0] sample_t;

endpackage

// File: rtl/ikaopm_acc_pairbuf.sv
// ikaopm_acc_pairbuf
//   Joins the accumulator's separate right/left sample strobes into R/L
//   pairs and offers them on a one-deep valid/ready output register.
//   Runs on every i_EMUCLK edge (not phi1-enable gated).
// Ports:
//   i_EMUCLK, i_MRST                 : clock, synchronous active-high reset
//   i_EMU_R_SAMPLE / i_EMU_R         : right sample strobe and value
//   i_EMU_L_SAMPLE / i_EMU_L         : left sample strobe and value (closes a pair)
//   o_PAIR_VALID / i_PAIR_READY      : output handshake
//   o_PAIR_R / o_PAIR_L              : held pair
//   o_OVERRUN / i_OVR_CLR            : sticky dropped-pair flag and its clear
module ikaopm_acc_pairbuf
  import ikaopm_pkg::*;
(
  input  logic    i_EMUCLK,
  input  logic    i_MRST,
  input  logic    i_EMU_R_SAMPLE,
  input  logic    i_EMU_L_SAMPLE,
  input  sample_t i_EMU_R,
  input  sample_t i_EMU_L,
  output logic    o_PAIR_VALID,
  input  logic    i_PAIR_READY,
  output sample_t o_PAIR_R,
  output sample_t o_PAIR_L,
  output logic    o_OVERRUN,
  input  logic    i_OVR_CLR
);

  sample_t r_hold_q, r_hold_d;
  logic    r_have_q, r_have_d;
  logic    valid_q,  valid_d;
  sample_t pair_r_q, pair_r_d;
  sample_t pair_l_q, pair_l_d;
  logic    ovr_q,    ovr_d;

  logic    pair_form;
  logic    pop;
  logic    accept;
  logic    drop;
  sample_t form_r;

  always_comb begin
    // A right strobe on the same edge as the left one takes effect first,
    // so the pair is built from the fresh right value.
    form_r    = i_EMU_R_SAMPLE ? i_EMU_R : r_hold_q;
    pair_form = i_EMU_L_SAMPLE & (r_have_q | i_EMU_R_SAMPLE);
    pop       = valid_q & i_PAIR_READY;
    accept    = pair_form & (~valid_q | pop);
    drop      = pair_form & valid_q & ~i_PAIR_READY;

    r_hold_d  = i_EMU_R_SAMPLE ? i_EMU_R : r_hold_q;
    r_have_d  = r_have_q;
    if (pair_form) begin
      r_have_d = 1'b0;
    end else if (i_EMU_R_SAMPLE) begin
      r_have_d = 1'b1;
    end

    valid_d  = valid_q;
    pair_r_d = pair_r_q;
    pair_l_d = pair_l_q;
    if (accept) begin
      valid_d  = 1'b1;
      pair_r_d = form_r;
      pair_l_d = i_EMU_L;
    end else if (pop) begin
      valid_d  = 1'b0;
    end

    // Set has priority over clear.
    ovr_d = drop | (ovr_q & ~i_OVR_CLR);
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_MRST) begin
      r_hold_q <= '0;
      r_have_q <= 1'b0;
      valid_q  <= 1'b0;
      pair_r_q <= '0;
      pair_l_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      r_hold_q <= r_hold_d;
      r_have_q <= r_have_d;
      valid_q  <= valid_d;
      pair_r_q <= pair_r_d;
      pair_l_q <= pair_l_d;
      ovr_q    <= ovr_d;
    end
  end

  assign o_PAIR_VALID = valid_q;
  assign o_PAIR_R     = pair_r_q;
  assign o_PAIR_L     = pair_l_q;
  assign o_OVERRUN    = ovr_q;

endmodule

// File: rtl/ikaopm_acc_sched.sv
// ikaopm_acc_sched
//   Accumulator scheduler: tracks the 32-cycle master frame from SYNC,
//   locks onto it after LOCK_COUNT consecutive aligned SYNCs, decodes
//   the accumulator timing strobes, gates the operator add request with
//   a frame-synchronous mute, and pairs the accumulator R/L outputs.
// Ports:
//   i_EMUCLK, i_MRST        : master clock, synchronous active-high reset
//   i_phi1_NCEN_n           : active-low enable, one per master cycle
//   i_SYNC                  : frame marker (master cycle 0)
//   i_OP_SNDADD, i_MUTE     : raw add request, mute request
//   o_CYCLE_*               : timing strobes, valid only while locked
//   o_ACC_SNDADD, o_LOCKED  : gated add enable, lock status
//   i_EMU_*                 : accumulator sample strobes and values
//   o_PAIR_*, i_PAIR_READY  : paired sample stream
//   o_OVERRUN, i_OVR_CLR    : sticky dropped-pair flag and clear
module ikaopm_acc_sched
  import ikaopm_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 2
) (
  input  logic    i_EMUCLK,
  input  logic    i_MRST,
  input  logic    i_phi1_NCEN_n,
  input  logic    i_SYNC,
  input  logic    i_OP_SNDADD,
  input  logic    i_MUTE,
  output logic    o_CYCLE_12,
  output logic    o_CYCLE_29,
  output logic    o_CYCLE_00_16,
  output logic    o_CYCLE_06_22,
  output logic    o_CYCLE_01_TO_16,
  output logic    o_ACC_SNDADD,
  output logic    o_LOCKED,
  input  logic    i_EMU_R_SAMPLE,
  input  logic    i_EMU_L_SAMPLE,
  input  sample_t i_EMU_R,
  input  sample_t i_EMU_L,
  output logic    o_PAIR_VALID,
  input  logic    i_PAIR_READY,
  output sample_t o_PAIR_R,
  output sample_t o_PAIR_L,
  output logic    o_OVERRUN,
  input  logic    i_OVR_CLR
);

  localparam int unsigned MW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [MW-1:0] MATCH_TARGET = MW'(LOCK_COUNT);

  lock_state_t   state_q, state_d;
  cyc_t          cyc_q,   cyc_d;
  logic [MW-1:0] match_q, match_d;
  logic          mute_q,  mute_d;

  logic          en;
  logic          at_zero;
  logic          aligned;
  logic          mismatch;
  logic [MW-1:0] match_inc;
  logic          locked;

  assign en        = ~i_phi1_NCEN_n;
  assign at_zero   = (cyc_q == CYC_00);
  assign aligned   = i_SYNC & at_zero;
  // Either SYNC off cycle 0, or cycle 0 without SYNC.
  assign mismatch  = i_SYNC ^ at_zero;
  assign match_inc = match_q + MW'(1);
  assign locked    = (state_q == ST_LOCKED);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    match_d = match_q;
    mute_d  = mute_q;
    if (en) begin
      // In every state SYNC realigns the counter to cycle 1; an aligned
      // SYNC arrives at cycle 0, so this also equals the free-run step.
      cyc_d = i_SYNC ? CYC_01 : cyc_q + 5'd1;
      if (cyc_q == CYC_31) begin
        mute_d = i_MUTE;
      end
      case (state_q)
        ST_UNLOCKED: begin
          if (i_SYNC) begin
            state_d = ST_ACQUIRE;
            match_d = '0;
          end
        end
        ST_ACQUIRE: begin
          if (aligned) begin
            if (match_inc == MATCH_TARGET) begin
              state_d = ST_LOCKED;
              match_d = '0;
            end else begin
              match_d = match_inc;
            end
          end else if (mismatch) begin
            match_d = '0;
          end
        end
        ST_LOCKED: begin
          if (mismatch) begin
            state_d = ST_ACQUIRE;
            match_d = '0;
          end
        end
        default: begin
          state_d = ST_UNLOCKED;
          match_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_MRST) begin
      state_q <= ST_UNLOCKED;
      cyc_q   <= CYC_00;
      match_q <= '0;
      mute_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      match_q <= match_d;
      mute_q  <= mute_d;
    end
  end

  assign o_LOCKED         = locked;
  assign o_CYCLE_12       = locked & (cyc_q == CYC_12);
  assign o_CYCLE_29       = locked & (cyc_q == CYC_29);
  assign o_CYCLE_00_16    = locked & ((cyc_q == CYC_00) | (cyc_q == CYC_16));
  assign o_CYCLE_06_22    = locked & ((cyc_q == CYC_06) | (cyc_q == CYC_22));
  assign o_CYCLE_01_TO_16 = locked & (cyc_q >= CYC_01) & (cyc_q <= CYC_16);
  assign o_ACC_SNDADD     = i_OP_SNDADD & ~mute_q & locked;

  ikaopm_acc_pairbuf u_pairbuf (
    .i_EMUCLK       (i_EMUCLK),
    .i_MRST         (i_MRST),
    .i_EMU_R_SAMPLE (i_EMU_R_SAMPLE),
    .i_EMU_L_SAMPLE (i_EMU_L_SAMPLE),
    .i_EMU_R        (i_EMU_R),
    .i_EMU_L        (i_EMU_L),
    .o_PAIR_VALID   (o_PAIR_VALID),
    .i_PAIR_READY   (i_PAIR_READY),
    .o_PAIR_R       (o_PAIR_R),
    .o_PAIR_L       (o_PAIR_L),
    .o_OVERRUN      (o_OVERRUN),
    .i_OVR_CLR      (i_OVR_CLR)
  );

endmodule

// File: tb/tb_ikaopm_acc_sched.sv
// tb_ikaopm_acc_sched
//   Directed bench for ikaopm_acc_sched: reset, lock acquisition/loss,
//   strobe decode, mute timing, pair handshake/overrun and mid-run reset.
module tb_ikaopm_acc_sched;

  logic        clk = 1'b0;
  logic        i_MRST, i_phi1_NCEN_n, i_SYNC, i_OP_SNDADD, i_MUTE;
  logic        o_CYCLE_12, o_CYCLE_29, o_CYCLE_00_16, o_CYCLE_06_22, o_CYCLE_01_TO_16;
  logic        o_ACC_SNDADD, o_LOCKED;
  logic        i_EMU_R_SAMPLE, i_EMU_L_SAMPLE;
  logic [15:0] i_EMU_R, i_EMU_L;
  logic        o_PAIR_VALID, i_PAIR_READY;
  logic [15:0] pair_r, pair_l;
  logic        o_OVERRUN, i_OVR_CLR;

  typedef struct {
    logic [15:0] r;
    logic [15:0] l;
  } pair_t;

  pair_t      sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [4:0] ecyc = 5'd0;
  int         n12;

  always #5 clk = ~clk;

  ikaopm_acc_sched #(.LOCK_COUNT(2)) dut (
    .i_EMUCLK         (clk),
    .i_MRST           (i_MRST),
    .i_phi1_NCEN_n    (i_phi1_NCEN_n),
    .i_SYNC           (i_SYNC),
    .i_OP_SNDADD      (i_OP_SNDADD),
    .i_MUTE           (i_MUTE),
    .o_CYCLE_12       (o_CYCLE_12),
    .o_CYCLE_29       (o_CYCLE_29),
    .o_CYCLE_00_16    (o_CYCLE_00_16),
    .o_CYCLE_06_22    (o_CYCLE_06_22),
    .o_CYCLE_01_TO_16 (o_CYCLE_01_TO_16),
    .o_ACC_SNDADD     (o_ACC_SNDADD),
    .o_LOCKED         (o_LOCKED),
    .i_EMU_R_SAMPLE   (i_EMU_R_SAMPLE),
    .i_EMU_L_SAMPLE   (i_EMU_L_SAMPLE),
    .i_EMU_R          (i_EMU_R),
    .i_EMU_L          (i_EMU_L),
    .o_PAIR_VALID     (o_PAIR_VALID),
    .i_PAIR_READY     (i_PAIR_READY),
    .o_PAIR_R         (pair_r),
    .o_PAIR_L         (pair_l),
    .o_OVERRUN        (o_OVERRUN),
    .i_OVR_CLR        (i_OVR_CLR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected strobes {12, 29, 00_16, 06_22, 01_TO_16} for a given cycle.
  function automatic logic [4:0] strobe_of(input logic [4:0] c);
    strobe_of = {c == 5'd12, c == 5'd29, (c == 5'd0) || (c == 5'd16),
                 (c == 5'd6) || (c == 5'd22), (c >= 5'd1) && (c <= 5'd16)};
  endfunction

  task automatic chk_strobes(input string tag, input logic lock);
    logic [4:0] exp;
    exp = lock ? strobe_of(ecyc) : 5'd0;
    chk(tag, 32'({o_CYCLE_12, o_CYCLE_29, o_CYCLE_00_16, o_CYCLE_06_22, o_CYCLE_01_TO_16}),
        32'(exp));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_locked"},  32'(o_LOCKED), 32'd0);
    chk({tag, "_strobes"}, 32'({o_CYCLE_12, o_CYCLE_29, o_CYCLE_00_16, o_CYCLE_06_22,
                                o_CYCLE_01_TO_16}), 32'd0);
    chk({tag, "_sndadd"},  32'(o_ACC_SNDADD), 32'd0);
    chk({tag, "_valid"},   32'(o_PAIR_VALID), 32'd0);
    chk({tag, "_pair"},    {pair_r, pair_l}, 32'd0);
    chk({tag, "_ovr"},     32'(o_OVERRUN), 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic en_step(input logic sync);
    i_phi1_NCEN_n = 1'b0;
    i_SYNC        = sync;
    step();
    i_SYNC = 1'b0;
    ecyc   = sync ? 5'd1 : ecyc + 5'd1;
  endtask

  task automatic dis_step(input logic sync);
    i_phi1_NCEN_n = 1'b1;
    i_SYNC        = sync;
    step();
    i_SYNC = 1'b0;
  endtask

  // 31 enables without SYNC then one with SYNC: SYNC spacing of 32 enables.
  task automatic run_frame(input string tag, input logic exp_lock, output int cnt12);
    cnt12 = 0;
    for (int i = 0; i < 32; i++) begin
      en_step(i == 31);
      if (o_CYCLE_12) cnt12++;
      if (i < 31) chk_strobes(tag, exp_lock);
    end
  endtask

  // Pair-domain edge with the phi1 enable held off; scoreboard pops on an
  // accepted handshake and compares the held pair whenever VALID is up.
  task automatic pstep();
    logic will_pop;
    will_pop = o_PAIR_VALID && i_PAIR_READY;
    dis_step(1'b0);
    i_EMU_R_SAMPLE = 1'b0;
    i_EMU_L_SAMPLE = 1'b0;
    i_OVR_CLR      = 1'b0;
    if (will_pop && sb.size() > 0) void'(sb.pop_front());
    if (o_PAIR_VALID) begin
      if (sb.size() == 0) begin
        chk("pair_unexpected", 32'(o_PAIR_VALID), 32'd0);
      end else begin
        chk("pair_R", 32'(pair_r), 32'(sb[0].r));
        chk("pair_L", 32'(pair_l), 32'(sb[0].l));
      end
    end
  endtask

  initial begin
    i_MRST = 1'b1; i_phi1_NCEN_n = 1'b0; i_SYNC = 1'b1; i_OP_SNDADD = 1'b1; i_MUTE = 1'b0;
    i_EMU_R_SAMPLE = 1'b0; i_EMU_L_SAMPLE = 1'b0; i_EMU_R = '0; i_EMU_L = '0;
    i_PAIR_READY = 1'b1; i_OVR_CLR = 1'b0;
    repeat (3) step();
    chk_all_zero("reset");

    // Lock acquisition
    i_MRST = 1'b0; i_SYNC = 1'b0; ecyc = 5'd0;
    en_step(1'b1);
    chk("lock_sync1", 32'(o_LOCKED), 32'd0);
    run_frame("acq_strobe1", 1'b0, n12);
    chk("acq_n12_1", 32'(n12), 32'd0);
    chk("lock_sync2", 32'(o_LOCKED), 32'd0);
    run_frame("acq_strobe2", 1'b0, n12);
    chk("lock_sync3", 32'(o_LOCKED), 32'd1);
    chk_strobes("lock_c1", 1'b1);
    chk("sndadd_locked", 32'(o_ACC_SNDADD), 32'd1);
    run_frame("lk_strobe", 1'b1, n12);
    chk("lk_n12", 32'(n12), 32'd1);
    chk("lk_hold", 32'(o_LOCKED), 32'd1);

    // Disabled edges freeze the counter and ignore SYNC
    repeat (3) en_step(1'b0);
    repeat (3) begin
      dis_step(1'b1);
      chk_strobes("en_gate", 1'b1);
      chk("en_gate_lock", 32'(o_LOCKED), 32'd1);
    end

    // Mute raised at cycle 5 only takes effect from the next frame
    en_step(1'b0);
    chk_strobes("mute_c5", 1'b1);
    i_MUTE = 1'b1;
    while (ecyc != 5'd31) begin
      en_step(1'b0);
      chk("mute_hold", 32'(o_ACC_SNDADD), 32'd1);
    end
    en_step(1'b0);
    chk_strobes("mute_c0_strobe", 1'b1);
    chk("mute_c0", 32'(o_ACC_SNDADD), 32'd0);
    en_step(1'b1);
    chk("mute_c1", 32'(o_ACC_SNDADD), 32'd0);
    chk("mute_c1_lock", 32'(o_LOCKED), 32'd1);
    i_MUTE = 1'b0;

    // Lock loss from SYNC at cycle 7, then relock
    while (ecyc != 5'd7) en_step(1'b0);
    en_step(1'b1);
    chk("loss_locked", 32'(o_LOCKED), 32'd0);
    chk_strobes("loss_strobes", 1'b0);
    run_frame("reacq_strobe1", 1'b0, n12);
    chk("relock_sync1", 32'(o_LOCKED), 32'd0);
    run_frame("reacq_strobe2", 1'b0, n12);
    chk("relock_sync2", 32'(o_LOCKED), 32'd1);
    chk_strobes("relock_c1", 1'b1);
    chk("relock_sndadd", 32'(o_ACC_SNDADD), 32'd1);

    // Normal handshake
    i_PAIR_READY = 1'b1;
    i_EMU_R = 16'h1234; i_EMU_R_SAMPLE = 1'b1;
    pstep();
    chk("hs_r_only", 32'(o_PAIR_VALID), 32'd0);
    i_EMU_L = 16'hFEDC; i_EMU_L_SAMPLE = 1'b1;
    sb.push_back('{16'h1234, 16'hFEDC});
    pstep();
    chk("hs_valid", 32'(o_PAIR_VALID), 32'd1);
    pstep();
    chk("hs_one_pulse", 32'(o_PAIR_VALID), 32'd0);
    i_EMU_L = 16'h5555; i_EMU_L_SAMPLE = 1'b1;
    pstep();
    chk("hs_lone_L", 32'(o_PAIR_VALID), 32'd0);
    pstep();
    chk("hs_lone_L2", 32'(o_PAIR_VALID), 32'd0);

    // Overrun
    i_PAIR_READY = 1'b0;
    i_EMU_R = 16'h1111; i_EMU_R_SAMPLE = 1'b1;
    pstep();
    i_EMU_L = 16'h2222; i_EMU_L_SAMPLE = 1'b1;
    sb.push_back('{16'h1111, 16'h2222});
    pstep();
    chk("ovr_first_valid", 32'(o_PAIR_VALID), 32'd1);
    chk("ovr_first_flag", 32'(o_OVERRUN), 32'd0);
    i_EMU_R = 16'h3333; i_EMU_R_SAMPLE = 1'b1;
    pstep();
    i_EMU_L = 16'h4444; i_EMU_L_SAMPLE = 1'b1;
    pstep();
    chk("ovr_set", 32'(o_OVERRUN), 32'd1);
    chk("ovr_held", 32'(o_PAIR_VALID), 32'd1);
    i_OVR_CLR = 1'b1; i_PAIR_READY = 1'b1;
    pstep();
    chk("ovr_clr", 32'(o_OVERRUN), 32'd0);
    chk("ovr_pop", 32'(o_PAIR_VALID), 32'd0);

    // Simultaneous R and L strobes use the new R
    i_PAIR_READY = 1'b0;
    i_EMU_R = 16'h0A0A; i_EMU_L = 16'h0B0B;
    i_EMU_R_SAMPLE = 1'b1; i_EMU_L_SAMPLE = 1'b1;
    sb.push_back('{16'h0A0A, 16'h0B0B});
    pstep();
    chk("rl_same_valid", 32'(o_PAIR_VALID), 32'd1);

    // New pair on the same edge as an accepted pop
    i_PAIR_READY = 1'b1;
    i_EMU_R = 16'h0C0C; i_EMU_L = 16'h0D0D;
    i_EMU_R_SAMPLE = 1'b1; i_EMU_L_SAMPLE = 1'b1;
    sb.push_back('{16'h0C0C, 16'h0D0D});
    pstep();
    chk("pop_load_valid", 32'(o_PAIR_VALID), 32'd1);
    chk("pop_load_ovr", 32'(o_OVERRUN), 32'd0);

    // Overrun set beats a simultaneous clear
    i_PAIR_READY = 1'b0;
    i_EMU_R = 16'h0E0E; i_EMU_L = 16'h0F0F;
    i_EMU_R_SAMPLE = 1'b1; i_EMU_L_SAMPLE = 1'b1; i_OVR_CLR = 1'b1;
    pstep();
    chk("set_wins", 32'(o_OVERRUN), 32'd1);
    i_OVR_CLR = 1'b1;
    pstep();
    chk("clr_alone", 32'(o_OVERRUN), 32'd0);
    i_EMU_R = 16'h7777; i_EMU_R_SAMPLE = 1'b1;
    pstep();
    chk("pre_rst_valid", 32'(o_PAIR_VALID), 32'd1);
    chk("pre_rst_lock", 32'(o_LOCKED), 32'd1);

    // Reset while holding a pair and locked
    i_MRST = 1'b1;
    step();
    chk_all_zero("midrst");
    sb.delete();
    i_MRST = 1'b0;
    i_EMU_L = 16'h0001; i_EMU_L_SAMPLE = 1'b1;
    pstep();
    chk("rst_rhave_valid", 32'(o_PAIR_VALID), 32'd0);
    chk("rst_rhave_ovr", 32'(o_OVERRUN), 32'd0);
    chk("rst_unlocked", 32'(o_LOCKED), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
